// File: rtl/stochastic_ct_collector.sv
// Receive end of the stochastic ciphertext link: counts ones on two lanes over a
// 2^W-bit window, rescales the counts and hands the rebuilt ciphertext out on valid/ready.
module stochastic_ct_collector #(
  parameter int W           = 10,
  parameter int SCALE_SHIFT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           bit_valid,
  input  logic           ser_a,
  input  logic           ser_b,
  output logic           ct_valid,
  input  logic           ct_ready,
  output logic [2*W-1:0] ct_out,
  output logic           busy,
  output logic           overrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [W-1:0] LAST_BIT = {W{1'b1}};
  localparam logic [W-1:0] ONE_BIT  = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [W:0]   cnt_a;
  logic [W:0]   cnt_b;
  logic [W-1:0] bit_cnt;

  // Counts including the bit presented this cycle; used for the last bit of a window.
  logic [W:0] cnt_a_inc;
  logic [W:0] cnt_b_inc;

  assign cnt_a_inc = cnt_a + {{W{1'b0}}, ser_a};
  assign cnt_b_inc = cnt_b + {{W{1'b0}}, ser_b};

  // Undo the MUX-adder averaging; wrapping mod 2^W matches ciphertext mod q.
  function automatic logic [W-1:0] scale(input logic [W:0] c);
    logic [W:0] s;
    s = c << SCALE_SHIFT;
    return s[W-1:0];
  endfunction

  // NOTE: every register here is written with <= so all state updates see the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt_a    <= '0;
      cnt_b    <= '0;
      bit_cnt  <= '0;
      ct_valid <= 1'b0;
      ct_out   <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_COLLECT;
            busy    <= 1'b1;
            cnt_a   <= '0;
            cnt_b   <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
          end
        end

        ST_COLLECT: begin
          if (start) begin
            // Restart: the bit sampled alongside start is discarded.
            cnt_a   <= '0;
            cnt_b   <= '0;
            bit_cnt <= '0;
          end else if (bit_valid) begin
            cnt_a   <= cnt_a_inc;
            cnt_b   <= cnt_b_inc;
            bit_cnt <= bit_cnt + ONE_BIT;
            if (bit_cnt == LAST_BIT) begin
              ct_out   <= {scale(cnt_a_inc), scale(cnt_b_inc)};
              ct_valid <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            if (start) begin
              state   <= ST_COLLECT;
              busy    <= 1'b1;
              cnt_a   <= '0;
              cnt_b   <= '0;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          ct_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stochastic_ct_collector.sv
// Directed bench for stochastic_ct_collector: stimulus pushes expected ciphertexts into
// a queue, a negedge monitor pops and compares them on every accepted handshake.
module tb_stochastic_ct_collector;

  localparam int W = 10;
  localparam int N = 1 << W;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           bit_valid;
  logic           ser_a;
  logic           ser_b;
  logic           ct_valid;
  logic           ct_ready;
  logic [2*W-1:0] ct_out;
  logic           busy;
  logic           overrun;

  int checks = 0;
  int errors = 0;
  int busy_bad = 0;
  logic [2*W-1:0] exp_q[$];

  localparam logic [2*W-1:0] EXP_T1 = {10'd512, 10'd176};
  localparam logic [2*W-1:0] EXP_T2 = {10'd0, 10'd0};

  stochastic_ct_collector #(.W(W), .SCALE_SHIFT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_valid(bit_valid),
    .ser_a    (ser_a),
    .ser_b    (ser_b),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct_out   (ct_out),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && ct_valid && ct_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ct", 32'(ct_out), 32'hFFFF_FFFF);
      end else begin
        check("ct_out", 32'(ct_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: lane A one every 4th bit (256 ones), lane B first 600 bits; mode 1: A=1, B=0.
  task automatic drive_bit(input int mode, input int i);
    bit_valid = 1'b1;
    if (mode == 0) begin
      ser_a = (i % 4 == 0);
      ser_b = (i < 600);
    end else begin
      ser_a = 1'b1;
      ser_b = 1'b0;
    end
  endtask

  task automatic stream(input int mode, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          bit_valid = 1'b0;
          ser_a     = $urandom_range(0, 1) == 1;
          ser_b     = $urandom_range(0, 1) == 1;
          tick();
          if (!busy) busy_bad++;
        end
      end
      drive_bit(mode, i);
      tick();
      if (!busy) busy_bad++;
    end
    bit_valid = 1'b0;
  endtask

  task automatic send_window(input int mode, input bit gaps, input logic [2*W-1:0] exp);
    busy_bad = 0;
    stream(mode, N - 1, gaps);
    exp_q.push_back(exp);
    drive_bit(mode, N - 1);
    check("valid_before_last", 32'(ct_valid), 32'd0);
    check("busy_before_last", 32'(busy), 32'd1);
    tick();
    bit_valid = 1'b0;
    check("valid_after_last", 32'(ct_valid), 32'd1);
    check("busy_after_last", 32'(busy), 32'd0);
    check("busy_in_window", 32'(busy_bad), 32'd0);
  endtask

  task automatic wait_accept();
    int n = 0;
    while (ct_valid && n < 10) begin
      tick();
      n++;
    end
    check("accept_timeout", 32'(ct_valid), 32'd0);
  endtask

  initial begin
    int stable_bad;
    rst       = 1'b1;
    start     = 1'b0;
    bit_valid = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    ct_ready  = 1'b0;
    repeat (3) tick();
    check("rst_ct_valid", 32'(ct_valid), 32'd0);
    check("rst_ct_out", 32'(ct_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: basic window, consumer always ready.
    ct_ready = 1'b1;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send_window(0, 1'b0, EXP_T1);
    wait_accept();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Test 2: lane A saturates at 2^W, scaled value wraps to 0.
    pulse_start();
    send_window(1, 1'b0, EXP_T2);
    wait_accept();

    // Test 3: stalls between valid bits.
    pulse_start();
    send_window(0, 1'b1, EXP_T1);
    wait_accept();

    // Test 4: result held while consumer stalls; start in HOLD flags overrun.
    ct_ready = 1'b0;
    pulse_start();
    send_window(0, 1'b0, EXP_T1);
    stable_bad = 0;
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      tick();
      if (ct_out !== EXP_T1 || ct_valid !== 1'b1) stable_bad++;
    end
    start = 1'b0;
    check("t4_hold_stable", 32'(stable_bad), 32'd0);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_hold_busy", 32'(busy), 32'd0);
    ct_ready = 1'b1;
    tick();
    check("t4_valid_drop", 32'(ct_valid), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_overrun_kept", 32'(overrun), 32'd1);

    // Start accepted from IDLE clears overrun; then start coincident with handshake.
    ct_ready = 1'b0;
    pulse_start();
    check("t5_overrun_clr", 32'(overrun), 32'd0);
    send_window(1, 1'b0, EXP_T2);
    start    = 1'b1;
    ct_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t5_hs_valid", 32'(ct_valid), 32'd0);
    check("t5_hs_busy", 32'(busy), 32'd1);
    check("t5_hs_overrun", 32'(overrun), 32'd0);

    // Test 5: restart mid-window discards the first 300 bits and the start-cycle bit.
    stream(1, 300, 1'b0);
    start     = 1'b1;
    bit_valid = 1'b1;
    ser_a     = 1'b1;
    ser_b     = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    send_window(0, 1'b0, EXP_T1);
    wait_accept();

    // Test 6: asynchronous reset mid-window loses the partial window.
    pulse_start();
    stream(0, 700, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(ct_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ct_out", 32'(ct_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("t6_post_rst_busy", 32'(busy), 32'd0);
    pulse_start();
    send_window(1, 1'b0, EXP_T2);
    wait_accept();

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
